// File: rtl/reflet_subword_mem_unit.sv
// reflet_subword_mem_unit
//   Byte-lane load/store adapter between the CPU address/ALU path and a
//   synchronous single-port RAM of width `wordsize`. Handles 8/16/32-bit and
//   full-word accesses at any lane. Sub-word stores use read-modify-write.
//   Loads are zero- or sign-extended. Misaligned accesses are flagged with
//   cpu_err and never touch the RAM.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cpu_req/cpu_ready request handshake (request sampled only while ready)
//   cpu_we            1=store, 0=load
//   cpu_size          00 full word, 01 32-bit, 10 16-bit, 11 8-bit
//   cpu_signed        sign-extend loads when 1
//   cpu_addr          byte address
//   cpu_wdata         right-aligned store data
//   cpu_rdata         right-aligned, extended load result (held)
//   cpu_ack, cpu_err  one-cycle completion pulse / misalignment flag
//   step              combinational effective byte count of cpu_size
//   ram_*             synchronous RAM port (read data valid one cycle later)
module reflet_subword_mem_unit #(
    parameter int unsigned wordsize   = 16,
    parameter int unsigned addr_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_signed,
    input  logic [addr_width-1:0] cpu_addr,
    input  logic [wordsize-1:0]   cpu_wdata,
    output logic [wordsize-1:0]   cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic [5:0]            step,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [wordsize-1:0]   ram_wdata,
    input  logic [wordsize-1:0]   ram_rdata
);

    localparam int unsigned NB = wordsize / 8;
    localparam logic [addr_width-1:0] LANE_MASK = addr_width'(NB - 1);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE, ERR} state_t;

    state_t                state, state_n;

    logic                  cap_we;
    logic                  cap_signed;
    logic                  cap_full;
    logic [5:0]            cap_esize;
    logic [5:0]            cap_lane;
    logic [addr_width-1:0] cap_addr;
    logic [wordsize-1:0]   cap_wdata;
    logic [wordsize-1:0]   merged;
    logic [wordsize-1:0]   rdata_q;

    logic [5:0]            req_bytes;
    logic [5:0]            esize_in;
    logic [5:0]            lane_in;
    logic                  misaligned;
    logic                  full_in;

    logic [wordsize-1:0]   shifted;
    logic [wordsize-1:0]   load_val;
    logic [wordsize-1:0]   merge_val;

    // Effective size: requested width only when strictly narrower than a word.
    always_comb begin
        case (cpu_size)
            2'b01:   req_bytes = 6'd4;
            2'b10:   req_bytes = 6'd2;
            2'b11:   req_bytes = 6'd1;
            default: req_bytes = 6'(NB);
        endcase
        esize_in = (req_bytes < 6'(NB)) ? req_bytes : 6'(NB);
    end

    assign step       = esize_in;
    assign lane_in    = 6'(cpu_addr & LANE_MASK);
    // esize is a power of two, so lane mod esize is a mask; a full word
    // masks the whole lane and therefore demands lane 0.
    assign misaligned = (lane_in & (esize_in - 6'd1)) != '0;
    assign full_in    = (esize_in == 6'(NB));

    // Lane extraction with extension, and lane insertion for the RMW write.
    always_comb begin
        int unsigned ebits;
        int unsigned lbit;
        shifted   = ram_rdata >> {cap_lane, 3'b000};
        load_val  = '0;
        merge_val = '0;
        ebits     = 8 * int'(cap_esize);
        lbit      = 8 * int'(cap_lane);
        for (int unsigned b = 0; b < wordsize; b++) begin
            if (b < ebits)
                load_val[b] = shifted[b];
            else
                load_val[b] = cap_signed & shifted[ebits-1];
            if (b >= lbit && b < lbit + ebits)
                merge_val[b] = cap_wdata[b-lbit];
            else
                merge_val[b] = ram_rdata[b];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we     <= 1'b0;
            cap_signed <= 1'b0;
            cap_full   <= 1'b0;
            cap_esize  <= '0;
            cap_lane   <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            merged     <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                cap_we     <= cpu_we;
                cap_signed <= cpu_signed;
                cap_full   <= full_in;
                cap_esize  <= esize_in;
                cap_lane   <= lane_in;
                cap_addr   <= cpu_addr & ~LANE_MASK;
                cap_wdata  <= cpu_wdata;
            end
            if (state == MERGE) begin
                if (cap_we)
                    merged <= merge_val;
                else
                    rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cpu_ready = 1'b0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    if (misaligned)
                        state_n = ERR;
                    else if (cpu_we && full_in)
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD: begin
                ram_en  = 1'b1;
                state_n = MERGE;
            end
            MERGE: state_n = cap_we ? WR : DONE;
            WR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                cpu_ack = 1'b1;
                state_n = IDLE;
            end
            ERR: begin
                cpu_ack = 1'b1;
                cpu_err = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Driven from capture registers only, so they stay quiet while idle.
    assign ram_addr  = cap_addr;
    assign ram_wdata = cap_full ? cap_wdata : merged;
    assign cpu_rdata = rdata_q;

endmodule

// File: doc/reflet_subword_mem_unit.md
Name: reflet_subword_mem_unit

Overview:
- Parametrised successor to the reduced-behaviour RAM adapter: sits between the address/ALU path and a synchronous single-port RAM.
- Performs 8/16/32-bit or full-word loads and stores at any byte lane inside a word of width `wordsize`.
- Sub-word stores are done as a read-modify-write (RMW) sequence. Loads offer zero or sign extension. Misaligned accesses are flagged instead of silently truncated.

Parameters:
wordsize, 16, CPU/RAM word width in bits; legal values 8, 16, 32, 64, 128
addr_width, 16, byte-address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
cpu_req  in  1  access request, sampled only when cpu_ready=1
cpu_ready  out  1  unit idle, can accept a request
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  reduced_behavior_bits encoding: 00 full word, 01 32-bit, 10 16-bit, 11 8-bit
cpu_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
cpu_addr  in  addr_width  byte address
cpu_wdata  in  wordsize  store data, right-aligned
cpu_rdata  out  wordsize  load result, right-aligned and extended; held until the next load completes
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  high together with cpu_ack when the access was misaligned
step  out  6  combinational byte count of the effective access size (replaces pop_offset)
ram_en  out  1  RAM cycle enable
ram_we  out  1  RAM write enable
ram_addr  out  addr_width  word-aligned byte address; low log2(wordsize/8) bits are 0
ram_wdata  out  wordsize  RAM write data
ram_rdata  in  wordsize  RAM read data, valid the cycle after ram_en=1, ram_we=0

Behaviour:
- Effective size
  - esize = size in bytes given by cpu_size: 4, 2 or 1.
  - esize is used only when it is strictly smaller than wordsize/8; otherwise the access is a full word of wordsize/8 bytes.
  - Example: size 01 with wordsize 16 is a full-word access.
  - step = effective byte count.
- Lanes
  - Little-endian: byte lane k = bits [8k+7:8k].
  - lane = cpu_addr mod (wordsize/8).
  - Misaligned when lane mod esize != 0. Full-word accesses require lane = 0.
- Reset
  - All outputs 0 except cpu_ready=1.
  - cpu_rdata = 0; internal capture registers = 0; state = IDLE.
  - Assertion mid-operation aborts immediately: ram_en drops asynchronously and no write completes.
- FSM states: IDLE, RD, MERGE, WR, DONE, ERR.
  - IDLE: cpu_ready=1.
    - On cpu_req, capture we/size/signed/addr/wdata and go to the next state.
    - Misaligned → ERR.
    - Full-word store → WR.
    - Any other access → RD.
    - cpu_req while not IDLE is ignored; the requester must hold it.
  - RD: ram_en=1, ram_we=0, ram_addr = aligned captured address.
  - MERGE: sample ram_rdata.
    - Load: cpu_rdata ← selected lane bytes, zero- or sign-extended from bit 8*esize-1; go to DONE.
    - Store: merged ← ram_rdata with lanes [lane, lane+esize) replaced by the low 8*esize bits of cpu_wdata; go to WR.
  - WR: ram_en=1, ram_we=1; ram_wdata = merged, or cpu_wdata for a full word. → DONE.
  - DONE: cpu_ack=1 for one cycle → IDLE.
  - ERR: cpu_ack=1, cpu_err=1 for one cycle; no RAM cycle is issued; cpu_rdata unchanged → IDLE.
- Latency (cycles after accept to ack)
  - Load: 3.
  - Sub-word store: 4.
  - Full-word store: 2.
  - Misaligned: 1.
  - A new request can be accepted the cycle after ack.
- ram_en=0 outside RD/WR. ram_addr and ram_wdata are don't-care when ram_en=0 but must not toggle in IDLE.
- For wordsize=8 every access is a full word; the RMW path is never entered.

Test Plan:
1. wordsize=32, RAM[0x10]=0xA1B2C3D4; load size=11, addr=0x12, signed=0 → ack at T+3, cpu_rdata=0x000000B2, exactly one ram_en cycle (read, addr 0x10).
2. Same as 1 with signed=1 → cpu_rdata=0xFFFFFFB2. Then size=10, addr=0x10, signed=1 → 0xFFFFC3D4.
3. Store size=10, addr=0x12, wdata=0x00001234 → RAM read at T+1, write at T+3 with ram_wdata=0x1234C3D4, ack at T+4. Reload full word returns 0x1234C3D4.
4. Store size=10, addr=0x11 → cpu_ack=1 and cpu_err=1 at T+1, ram_en never asserted, RAM unchanged.
5. wordsize=16, size=01 store addr=0x4 wdata=0xBEEF → treated as full word: write at T+1, ack at T+2, step=2. Size=11 gives step=1.
6. Drive reset low during MERGE of a sub-word store → ram_en=0 immediately, cpu_ready=1 after release, RAM word unmodified, cpu_rdata=0.
